// File: rtl/apb_master_bridge_pkg.sv
// Shared types and defaults for the APB requester bridge.
// Imported by the bridge top and its slave decoder.
package apb_master_bridge_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_PADDR_W = 5;
  localparam int DEF_NSLV    = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // A single slave still needs a one-bit select field.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_bridge_decoder.sv
// Slave decode for the APB bridge: address -> slave index and
// decode error, latched index -> one-hot select and return-path mux.
module apb_slave_decoder
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PADDR_W = DEF_PADDR_W,
  parameter int NSLV    = DEF_NSLV,
  parameter int SEL_W   = sel_width(DEF_NSLV)
) (
  input  logic [ADDR_W-PADDR_W-1:0] i_addr_hi,
  input  logic [SEL_W-1:0]          i_sel_idx,
  input  logic [NSLV*DATA_W-1:0]    i_prdata,
  input  logic [NSLV-1:0]           i_pready,
  input  logic [NSLV-1:0]           i_pslverr,
  output logic [SEL_W-1:0]          o_req_idx,
  output logic                      o_dec_err,
  output logic [NSLV-1:0]           o_sel,
  output logic [DATA_W-1:0]         o_prdata,
  output logic                      o_pready,
  output logic                      o_pslverr
);

  localparam int HI_W = ADDR_W - PADDR_W;

  logic w_hi_err;
  logic w_idx_err;

  assign o_req_idx = i_addr_hi[SEL_W-1:0];

  if (HI_W > SEL_W) begin : g_hi
    assign w_hi_err = |i_addr_hi[HI_W-1:SEL_W];
  end else begin : g_nohi
    assign w_hi_err = 1'b0;
  end

  assign w_idx_err =
    ({1'b0, o_req_idx} >= (SEL_W+1)'(NSLV));

  assign o_dec_err = w_hi_err | w_idx_err;

  always_comb begin
    o_sel     = '0;
    o_prdata  = '0;
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (i_sel_idx == SEL_W'(i)) begin
        o_sel[i]  = 1'b1;
        o_prdata  = i_prdata[i*DATA_W +: DATA_W];
        o_pready  = i_pready[i];
        o_pslverr = i_pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: takes one single-beat core request, runs the
// SETUP/ACCESS sequence on the decoded slave, returns a response pulse.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PADDR_W = DEF_PADDR_W,
  parameter int NSLV    = DEF_NSLV,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [PADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [NSLV*DATA_W-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR
);

  localparam int SEL_W = sel_width(NSLV);
  localparam int CNT_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e         r_state;
  logic [SEL_W-1:0]   r_idx;
  logic               r_pwrite;
  logic [PADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0]  r_pwdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_rdata;

  apb_state_e         w_state_nxt;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic               w_pwrite_nxt;
  logic [PADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0]  w_pwdata_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_rsp_valid_nxt;
  logic               w_rsp_err_nxt;
  logic [DATA_W-1:0]  w_rsp_rdata_nxt;
  logic               w_timeout;

  logic [SEL_W-1:0]   w_req_idx;
  logic               w_dec_err;
  logic [NSLV-1:0]    w_sel;
  logic [DATA_W-1:0]  w_prdata;
  logic               w_pready;
  logic               w_pslverr;

  apb_slave_decoder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .PADDR_W (PADDR_W),
    .NSLV    (NSLV),
    .SEL_W   (SEL_W)
  ) u_dec (
    .i_addr_hi (req_addr[ADDR_W-1:PADDR_W]),
    .i_sel_idx (r_idx),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR),
    .o_req_idx (w_req_idx),
    .o_dec_err (w_dec_err),
    .o_sel     (w_sel),
    .o_prdata  (w_prdata),
    .o_pready  (w_pready),
    .o_pslverr (w_pslverr)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT != 0) &&
                     (w_cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_dec_err) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt  = ST_SETUP;
            w_idx_nxt    = w_req_idx;
            w_pwrite_nxt = req_write;
            w_paddr_nxt  = req_addr[PADDR_W-1:0];
            w_pwdata_nxt = req_wdata;
            w_cnt_nxt    = '0;
          end
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_pready) begin
          w_state_nxt     = ST_IDLE;
          w_cnt_nxt       = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = w_pslverr;
          if (!r_pwrite && !w_pslverr)
            w_rsp_rdata_nxt = w_prdata;
        end else if (w_timeout) begin
          w_state_nxt     = ST_IDLE;
          w_cnt_nxt       = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign PSEL      = (r_state != ST_IDLE) ? w_sel : '0;
  assign PENABLE   = (r_state == ST_ACCESS);
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
